// File: rtl/bus_fabric.sv
// Memory-map interconnect: registered region decode, per-region wait states, ready handshake,
// sticky unmapped-access error and last-access monitor. Define BUS_FABRIC_ACCESS_CNT_EN for rd/wr counters.
module bus_fabric #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int N_REG  = 4,
  parameter logic [N_REG*ADDR_W-1:0] REG_BASE = {8'hFF, 8'h24, 8'h20, 8'h00},
  parameter logic [N_REG*ADDR_W-1:0] REG_MASK = {8'hFF, 8'hFC, 8'hFC, 8'hE0},
  parameter logic [N_REG*4-1:0]      REG_WAIT = {4'd0, 4'd1, 4'd0, 4'd0}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       adrs,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    ready,
  output logic [N_REG-1:0]        s_cs,
  output logic                    s_rd,
  output logic                    s_wr,
  output logic [ADDR_W-1:0]       s_adrs,
  output logic [DATA_W-1:0]       s_wdata,
  input  logic [N_REG*DATA_W-1:0] s_rdata,
  output logic                    bus_err,
  output logic [ADDR_W-1:0]       last_adrs,
  output logic [DATA_W-1:0]       last_data
`ifdef BUS_FABRIC_ACCESS_CNT_EN
  ,
  output logic [15:0]             rd_cnt,
  output logic [15:0]             wr_cnt
`endif
);
  localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ERR, S_ACK, S_HOLD} state_t;
  state_t state, state_nx;

  logic [IDX_W-1:0] idx, hit_idx;
  logic             hit, is_rd, is_err;
  logic [3:0]       wcnt;

  // Scan high to low so the lowest-index hit is the one that sticks.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_REG - 1; k >= 0; k--) begin
      if ((adrs & REG_MASK[k*ADDR_W +: ADDR_W]) == REG_BASE[k*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (mem_read && mem_write)     state_nx = S_ERR;
        else if (mem_read ^ mem_write) state_nx = hit ? S_WAIT : S_ERR;
      end
      S_WAIT:  if (wcnt == 4'd0) state_nx = S_ACK;
      S_ERR:   state_nx = S_ACK;
      S_ACK:   state_nx = S_HOLD;
      S_HOLD:  if (!mem_read && !mem_write) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < N_REG; k++)
      s_cs[k] = (state == S_WAIT) && (idx == IDX_W'(k));
    s_rd  = (state == S_WAIT) && (wcnt == 4'd0) && is_rd;
    s_wr  = (state == S_WAIT) && (wcnt == 4'd0) && !is_rd;
    ready = (state == S_ACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      is_rd     <= 1'b0;
      is_err    <= 1'b0;
      wcnt      <= '0;
      s_adrs    <= '0;
      s_wdata   <= '0;
      cpu_rdata <= '0;
      bus_err   <= 1'b0;
      last_adrs <= '0;
      last_data <= '0;
`ifdef BUS_FABRIC_ACCESS_CNT_EN
      rd_cnt    <= '0;
      wr_cnt    <= '0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (mem_read || mem_write) begin
          s_adrs  <= adrs;
          s_wdata <= cpu_wdata;
          idx     <= hit_idx;
          is_rd   <= mem_read;
          is_err  <= (mem_read && mem_write) || !hit;
          wcnt    <= REG_WAIT[hit_idx*4 +: 4];
        end
        S_WAIT: begin
          if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
          else if (is_rd)   cpu_rdata <= s_rdata[idx*DATA_W +: DATA_W];
        end
        S_ERR: begin
          cpu_rdata <= '1;
          bus_err   <= 1'b1;
        end
        S_ACK: begin
          last_adrs <= s_adrs;
          last_data <= is_rd ? cpu_rdata : s_wdata;
`ifdef BUS_FABRIC_ACCESS_CNT_EN
          if (!is_err && is_rd && rd_cnt != 16'hFFFF)  rd_cnt <= rd_cnt + 16'd1;
          if (!is_err && !is_rd && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: directed scenarios plus randomized accesses
// compared against a table-driven memory-map model.
module tb_bus_fabric;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  adrs, cpu_wdata, cpu_rdata, s_adrs, s_wdata, last_adrs, last_data;
  logic        mem_read, mem_write, ready, s_rd, s_wr, bus_err;
  logic [3:0]  s_cs;
  logic [31:0] s_rdata;
`ifdef BUS_FABRIC_ACCESS_CNT_EN
  logic [15:0] rd_cnt, wr_cnt;
`endif

  // RAM (0x20) and IO (0x24) each get one wait state.
  localparam logic [15:0] TB_WAIT_P = {4'd0, 4'd1, 4'd1, 4'd0};
  localparam logic [7:0]  TB_BASE [4] = '{8'h00, 8'h20, 8'h24, 8'hFF};
  localparam logic [7:0]  TB_MASK [4] = '{8'hE0, 8'hFC, 8'hFC, 8'hFF};
  localparam int          TB_WAIT [4] = '{0, 1, 1, 0};

  bus_fabric #(.REG_WAIT(TB_WAIT_P)) dut (
    .clk(clk), .rst(rst), .adrs(adrs), .mem_read(mem_read), .mem_write(mem_write),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .ready(ready), .s_cs(s_cs),
    .s_rd(s_rd), .s_wr(s_wr), .s_adrs(s_adrs), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .bus_err(bus_err), .last_adrs(last_adrs), .last_data(last_data)
`ifdef BUS_FABRIC_ACCESS_CNT_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model state
  logic [7:0] m_rdata, m_last_adrs, m_last_data;
  logic       m_err;
  int         m_rd_cnt, m_wr_cnt;
  int         exp_reg, exp_lat;
  logic       exp_err;

  // observations from the last access
  int         o_ready_cyc, o_n_ready, o_n_rd, o_n_wr, o_strobe_cyc, o_cs_seen;
  logic [3:0] o_cs_strobe;
  logic [7:0] o_wdata_strobe;
  logic       o_bad;

  function automatic int decode(input logic [7:0] a);
    for (int k = 0; k < 4; k++)
      if ((a & TB_MASK[k]) == TB_BASE[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_rdata = 8'h00; m_last_adrs = 8'h00; m_last_data = 8'h00; m_err = 1'b0;
    m_rd_cnt = 0; m_wr_cnt = 0;
  endtask

  task automatic model_access(input logic rd, input logic wr, input logic [7:0] a,
                              input logic [7:0] wd, input logic [31:0] srd);
    exp_reg = decode(a);
    exp_err = (rd && wr) || (exp_reg < 0);
    exp_lat = exp_err ? 2 : TB_WAIT[exp_reg] + 2;
    if (exp_err) begin
      m_rdata = 8'hFF;
      m_err   = 1'b1;
    end else if (rd) begin
      m_rdata = srd[exp_reg*8 +: 8];
    end
    m_last_adrs = a;
    m_last_data = rd ? m_rdata : wd;
    if (!exp_err && rd && m_rd_cnt < 65535) m_rd_cnt++;
    if (!exp_err && !rd && m_wr_cnt < 65535) m_wr_cnt++;
  endtask

  // Drives one request; keep>0 drops it after keep cycles, keep==0 drops it on ready.
  task automatic run_access(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [7:0] wd, input logic [31:0] srd, input int keep);
    int stop;
    o_ready_cyc = -1; o_n_ready = 0; o_n_rd = 0; o_n_wr = 0; o_strobe_cyc = -1;
    o_cs_seen = 0; o_cs_strobe = '0; o_wdata_strobe = '0; o_bad = 1'b0;
    @(negedge clk);
    adrs = a; cpu_wdata = wd; s_rdata = srd; mem_read = rd; mem_write = wr;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin
        if (o_ready_cyc < 0) o_ready_cyc = c;
        o_n_ready++;
      end
      if (s_rd || s_wr) begin
        o_strobe_cyc = c; o_cs_strobe = s_cs; o_wdata_strobe = s_wdata;
      end
      if (s_rd) o_n_rd++;
      if (s_wr) o_n_wr++;
      if (s_cs != 4'b0) o_cs_seen++;
      if (!$onehot0(s_cs) || (s_rd && s_wr)) o_bad = 1'b1;
      if ((keep > 0) ? (c >= keep) : (o_ready_cyc >= 0)) begin
        mem_read = 1'b0; mem_write = 1'b0;
      end
      stop = ((keep > o_ready_cyc) ? keep : o_ready_cyc) + 3;
      if (o_ready_cyc >= 0 && c >= stop) break;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] all_out;
    all_out = {cpu_rdata, ready, s_cs, s_rd, s_wr, s_adrs, s_wdata, bus_err, last_adrs, last_data};
    checks++;
    if (all_out !== 64'd0) begin
      errors++; $display("FAIL reset_outputs: got %0h want 0", all_out);
    end
`ifdef BUS_FABRIC_ACCESS_CNT_EN
    checks++;
    if ({rd_cnt, wr_cnt} !== 32'd0) begin
      errors++; $display("FAIL reset_counters: got %0h want 0", {rd_cnt, wr_cnt});
    end
`endif
  endtask

  task automatic test_read_rom();
    model_access(1'b1, 1'b0, 8'h05, 8'h00, 32'h1122333C);
    run_access(1'b1, 1'b0, 8'h05, 8'h00, 32'h1122333C, 0);
    checks += 6;
    if (o_ready_cyc != 2) begin errors++; $display("FAIL rom_ready_cyc: got %0d want 2", o_ready_cyc); end
    if (o_strobe_cyc != 1 || o_n_rd != 1 || o_n_wr != 0) begin
      errors++; $display("FAIL rom_strobe: got cyc %0d rd %0d wr %0d want 1 1 0", o_strobe_cyc, o_n_rd, o_n_wr);
    end
    if (o_cs_strobe !== 4'b0001) begin errors++; $display("FAIL rom_cs: got %b want 0001", o_cs_strobe); end
    if (cpu_rdata !== 8'h3C) begin errors++; $display("FAIL rom_rdata: got %0h want 3c", cpu_rdata); end
    if (last_adrs !== 8'h05 || last_data !== 8'h3C) begin
      errors++; $display("FAIL rom_last: got %0h/%0h want 05/3c", last_adrs, last_data);
    end
    if (bus_err !== 1'b0) begin errors++; $display("FAIL rom_bus_err: got %b want 0", bus_err); end
  endtask

  task automatic test_write_ram();
    model_access(1'b0, 1'b1, 8'h22, 8'hA5, 32'h0);
    run_access(1'b0, 1'b1, 8'h22, 8'hA5, 32'h0, 0);
    checks += 5;
    if (o_ready_cyc != 3) begin errors++; $display("FAIL ram_ready_cyc: got %0d want 3", o_ready_cyc); end
    if (o_strobe_cyc != 2 || o_n_wr != 1 || o_n_rd != 0) begin
      errors++; $display("FAIL ram_strobe: got cyc %0d wr %0d rd %0d want 2 1 0", o_strobe_cyc, o_n_wr, o_n_rd);
    end
    if (o_wdata_strobe !== 8'hA5 || o_cs_strobe !== 4'b0010) begin
      errors++; $display("FAIL ram_wdata_cs: got %0h/%b want a5/0010", o_wdata_strobe, o_cs_strobe);
    end
    if (last_adrs !== 8'h22) begin errors++; $display("FAIL ram_last_adrs: got %0h want 22", last_adrs); end
    if (last_data !== 8'hA5) begin errors++; $display("FAIL ram_last_data: got %0h want a5", last_data); end
  endtask

  task automatic test_unmapped();
    model_access(1'b1, 1'b0, 8'h80, 8'h00, 32'h55555555);
    run_access(1'b1, 1'b0, 8'h80, 8'h00, 32'h55555555, 0);
    checks += 4;
    if (o_ready_cyc != 2) begin errors++; $display("FAIL unmapped_ready_cyc: got %0d want 2", o_ready_cyc); end
    if (o_cs_seen != 0 || o_n_rd != 0 || o_n_wr != 0) begin
      errors++; $display("FAIL unmapped_no_select: got cs %0d rd %0d wr %0d want 0 0 0", o_cs_seen, o_n_rd, o_n_wr);
    end
    if (cpu_rdata !== 8'hFF) begin errors++; $display("FAIL unmapped_rdata: got %0h want ff", cpu_rdata); end
    if (bus_err !== 1'b1) begin errors++; $display("FAIL unmapped_bus_err: got %b want 1", bus_err); end
    model_access(1'b1, 1'b0, 8'h10, 8'h00, 32'h000000C7);
    run_access(1'b1, 1'b0, 8'h10, 8'h00, 32'h000000C7, 0);
    checks += 2;
    if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_sticky: got %b want 1", bus_err); end
    if (cpu_rdata !== 8'hC7) begin errors++; $display("FAIL after_err_rdata: got %0h want c7", cpu_rdata); end
  endtask

  task automatic test_held_request();
    model_access(1'b1, 1'b0, 8'h25, 8'h00, 32'h00990000);
    run_access(1'b1, 1'b0, 8'h25, 8'h00, 32'h00990000, 10);
    checks += 3;
    if (o_n_rd != 1 || o_n_ready != 1) begin
      errors++; $display("FAIL held_single: got rd %0d ready %0d want 1 1", o_n_rd, o_n_ready);
    end
    if (o_cs_seen != 2 || o_ready_cyc != 3) begin
      errors++; $display("FAIL held_timing: got cs %0d ready_cyc %0d want 2 3", o_cs_seen, o_ready_cyc);
    end
    if (cpu_rdata !== 8'h99) begin errors++; $display("FAIL held_rdata: got %0h want 99", cpu_rdata); end
    model_access(1'b1, 1'b0, 8'h01, 8'h00, 32'h00000042);
    run_access(1'b1, 1'b0, 8'h01, 8'h00, 32'h00000042, 0);
    checks++;
    if (o_ready_cyc != 2 || cpu_rdata !== 8'h42) begin
      errors++; $display("FAIL held_next: got cyc %0d data %0h want 2 42", o_ready_cyc, cpu_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] all_out;
    int strobes;
    strobes = 0;
    @(negedge clk);
    adrs = 8'h22; cpu_wdata = 8'h5A; mem_write = 1'b1;
    @(negedge clk);
    rst = 1'b1; mem_write = 1'b0;
    #1;
    all_out = {cpu_rdata, ready, s_cs, s_rd, s_wr, s_adrs, s_wdata, bus_err, last_adrs, last_data};
    checks++;
    if (all_out !== 64'd0) begin errors++; $display("FAIL midreset_outputs: got %0h want 0", all_out); end
    model_reset();
    repeat (2) begin @(negedge clk); if (s_wr || s_rd || ready) strobes++; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (s_wr || s_rd || ready) strobes++; end
    checks++;
    if (strobes != 0) begin errors++; $display("FAIL midreset_no_strobe: got %0d want 0", strobes); end
    model_access(1'b1, 1'b0, 8'h00, 8'h00, 32'h0000006E);
    run_access(1'b1, 1'b0, 8'h00, 8'h00, 32'h0000006E, 0);
    checks++;
    if (o_ready_cyc != 2 || cpu_rdata !== 8'h6E || o_n_rd != 1) begin
      errors++; $display("FAIL midreset_followup: got cyc %0d data %0h rd %0d want 2 6e 1", o_ready_cyc, cpu_rdata, o_n_rd);
    end
  endtask

  task automatic test_random();
    logic [7:0]  a, wd;
    logic [31:0] srd;
    logic        rd, wr;
    int          kind, keep;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: a = 8'($urandom_range(0, 31));
        1: a = 8'($urandom_range(32, 35));
        2: a = 8'($urandom_range(36, 39));
        3: a = 8'hFF;
        default: a = 8'($urandom);
      endcase
      kind = $urandom_range(0, 9);
      rd = (kind < 5) || (kind == 9);
      wr = (kind >= 5);
      wd = 8'($urandom); srd = $urandom;
      keep = ($urandom_range(0, 3) == 0) ? 1 : 0;
      model_access(rd, wr, a, wd, srd);
      run_access(rd, wr, a, wd, srd, keep);
      checks += 6;
      if (o_ready_cyc != exp_lat || o_n_ready != 1) begin
        errors++; $display("FAIL rand_ready a=%0h: got cyc %0d n %0d want %0d 1", a, o_ready_cyc, o_n_ready, exp_lat);
      end
      if (o_n_rd != ((!exp_err && rd) ? 1 : 0) || o_n_wr != ((!exp_err && !rd) ? 1 : 0) || o_bad) begin
        errors++; $display("FAIL rand_strobes a=%0h: got rd %0d wr %0d bad %b", a, o_n_rd, o_n_wr, o_bad);
      end
      if (o_cs_seen != (exp_err ? 0 : exp_lat - 1) ||
          (!exp_err && (o_cs_strobe !== 4'(1 << exp_reg) || o_strobe_cyc != exp_lat - 1))) begin
        errors++; $display("FAIL rand_select a=%0h: got cs %b seen %0d cyc %0d want reg %0d", a, o_cs_strobe, o_cs_seen, o_strobe_cyc, exp_reg);
      end
      if (cpu_rdata !== m_rdata || bus_err !== m_err) begin
        errors++; $display("FAIL rand_rdata a=%0h: got %0h/%b want %0h/%b", a, cpu_rdata, bus_err, m_rdata, m_err);
      end
      if (last_adrs !== m_last_adrs || last_data !== m_last_data) begin
        errors++; $display("FAIL rand_last: got %0h/%0h want %0h/%0h", last_adrs, last_data, m_last_adrs, m_last_data);
      end
      if (s_adrs !== a) begin errors++; $display("FAIL rand_s_adrs: got %0h want %0h", s_adrs, a); end
`ifdef BUS_FABRIC_ACCESS_CNT_EN
      checks++;
      if (rd_cnt !== 16'(m_rd_cnt) || wr_cnt !== 16'(m_wr_cnt)) begin
        errors++; $display("FAIL rand_counts: got %0d/%0d want %0d/%0d", rd_cnt, wr_cnt, m_rd_cnt, m_wr_cnt);
      end
`endif
    end
  endtask

`ifdef BUS_FABRIC_ACCESS_CNT_EN
  task automatic test_counters();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    run_access(1'b1, 1'b0, 8'h03, 8'h00, 32'h1, 0);
    run_access(1'b0, 1'b1, 8'h21, 8'h11, 32'h0, 0);
    run_access(1'b1, 1'b0, 8'h26, 8'h00, 32'h2, 0);
    run_access(1'b1, 1'b0, 8'h90, 8'h00, 32'h3, 0);
    run_access(1'b0, 1'b1, 8'hFF, 8'h22, 32'h0, 0);
    run_access(1'b1, 1'b0, 8'hFF, 8'h00, 32'h4, 0);
    checks++;
    if (rd_cnt !== 16'd3 || wr_cnt !== 16'd2) begin
      errors++; $display("FAIL counters: got %0d/%0d want 3/2", rd_cnt, wr_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    adrs = '0; cpu_wdata = '0; s_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_read_rom();
    test_write_ram();
    test_unmapped();
    test_held_request();
    test_reset_mid();
    test_random();
`ifdef BUS_FABRIC_ACCESS_CNT_EN
    test_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised memory-map interconnect between the CPU bus and N_REG slave regions (ROM, RAM, IO, ...).
- Replaces fixed combinational chip-select and readback muxing with a registered decoder, per-region wait states, a ready handshake, unmapped-access error capture and a last-access monitor for the 7-seg debug view.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- N_REG, 4, number of slave regions (1..8).
- REG_BASE, {8'hFF,8'h24,8'h20,8'h00}, packed N_REG*ADDR_W; region k base at slice k.
- REG_MASK, {8'hFF,8'hFC,8'hFC,8'hE0}, packed N_REG*ADDR_W; region k hit when (adrs & mask_k) == base_k.
- REG_WAIT, {4'd0,4'd1,4'd0,4'd0}, packed N_REG*4; wait cycles inserted for region k.

Ports:
- clk  in  1  bus clock.
- rst  in  1  asynchronous reset, active-high.
- adrs  in  ADDR_W  CPU address.
- mem_read  in  1  read request (level, held until ready).
- mem_write  in  1  write request (level, held until ready).
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data to CPU, registered.
- ready  out  1  one-cycle completion pulse.
- s_cs  out  N_REG  one-hot region select.
- s_rd  out  1  slave read strobe.
- s_wr  out  1  slave write strobe.
- s_adrs  out  ADDR_W  latched address to slaves.
- s_wdata  out  DATA_W  latched write data.
- s_rdata  in  N_REG*DATA_W  packed slave read data, slice k = region k.
- bus_err  out  1  sticky error flag.
- last_adrs  out  ADDR_W  address of last completed access.
- last_data  out  DATA_W  data of last completed access.

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared.
- Decode: lowest-index region hit wins on overlap; no hit = unmapped.
- FSM IDLE: on (mem_read ^ mem_write):
  - Latch adrs, cpu_wdata, region index and direction.
  - Load wcnt = REG_WAIT[k]; go WAIT.
  - If mem_read & mem_write both high, go ERR.
- WAIT:
  - s_cs[k] high.
  - wcnt != 0: decrement.
  - wcnt == 0: assert s_rd or s_wr for exactly this cycle; register cpu_rdata <= s_rdata[k] on a read; go ACK.
  - Latency from request to ready = REG_WAIT[k] + 2 cycles.
- ACK:
  - ready = 1 for one cycle; s_cs deasserted.
  - last_adrs/last_data updated; last_data = write data or read data.
  - Go HOLD.
- HOLD: wait until mem_read == mem_write == 0, then IDLE. Prevents double access on a held request.
- Unmapped access or simultaneous rd+wr: go ERR.
  - No s_cs/s_rd/s_wr.
  - cpu_rdata = all ones; bus_err set (sticky until rst).
  - Next cycle ACK as normal.
- Request dropped during WAIT: access still completes; ready pulses; then HOLD exits immediately.
- s_cs is never multi-hot; s_rd and s_wr are never high together.
- Reset mid-access: aborts immediately; no strobe is issued after rst deasserts.

Optional Feature:
- Macro: BUS_FABRIC_ACCESS_CNT_EN.
- Defined: adds outputs rd_cnt and wr_cnt (16 bits each), incremented in ACK for completed reads/writes excluding ERR. Counts saturate at 16'hFFFF and are cleared by rst.
- Undefined: ports and logic absent; the rest of the behaviour is identical.

Test Plan:
- Read 0x05 (ROM, 0 waits), s_rdata slice0 = 8'h3C -> s_rd at cycle 1, ready at cycle 2, cpu_rdata = 8'h3C, s_cs = 4'b0001.
- Write 0x22 (RAM, 1 wait) with 8'hA5 -> s_wr high exactly one cycle at cycle 2, s_wdata = 8'hA5, ready at cycle 3, last_adrs = 8'h22, last_data = 8'hA5.
- Read 0x80 (unmapped) -> no s_cs, ready at cycle 2, cpu_rdata = 8'hFF, bus_err = 1 and remains set after later good accesses.
- Hold mem_read high for 10 cycles on 0x25 -> exactly one s_rd pulse and one ready pulse; next access starts only after the request drops.
- Assert rst during WAIT of a RAM write -> s_wr never pulses, all outputs 0, following read 0x00 completes normally.
- With BUS_FABRIC_ACCESS_CNT_EN defined: 3 reads, 2 writes, 1 unmapped -> rd_cnt = 3, wr_cnt = 2.
